// File: rtl/watch_time_setter_pkg.sv
// Shared types and limits for the watch time-setting path.
// Edit FSM states, field indices and per-field wrap maxima.
package watch_time_setter_pkg;

  localparam int FIELD_W = 6;

  localparam logic [FIELD_W-1:0] HOURS_MAX  = 6'd23;
  localparam logic [FIELD_W-1:0] MINSEC_MAX = 6'd59;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    EDIT_H = 2'd1,
    EDIT_M = 2'd2,
    EDIT_S = 2'd3
  } state_t;

  // Bit position of each field inside the {h,m,s} blink mask.
  typedef enum logic [1:0] {
    FLD_S = 2'd0,
    FLD_M = 2'd1,
    FLD_H = 2'd2
  } field_t;

endpackage

// File: rtl/button_debouncer.sv
// Raw button to single-cycle press pulse: 2-FF synchronizer, stability
// debouncer and rising-edge detector on the debounced level.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             level;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      // stage p0/p1: metastability guard
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      press   <= 1'b0;
      // any agreement with the current level restarts the stability count
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_p1;
        cnt   <= '0;
        press <= sync_p1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/watch_time_setter.sv
// Button-driven time editor: captures the running time, lets the user
// step hours/minutes/seconds with wrap-around, and loads the result back.
module watch_time_setter
  import watch_time_setter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int BLINK_CYCLES    = 50_000_000
) (
  input  logic               CLK100MHZ,
  input  logic               reset,
  input  logic               BTNC,
  input  logic               BTNU,
  input  logic               BTND,
  input  logic [FIELD_W-1:0] horas_in,
  input  logic [FIELD_W-1:0] minutos_in,
  input  logic [FIELD_W-1:0] segundos_in,
  output logic [FIELD_W-1:0] horas_set,
  output logic [FIELD_W-1:0] minutos_set,
  output logic [FIELD_W-1:0] segundos_set,
  output logic               load,
  output logic               editing,
  output logic [2:0]         blink_mask
);

  localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

  logic mode_p, up_p, down_p;
  logic step_up, step_dn;
  state_t state, state_nxt;
  field_t active;
  logic [FIELD_W-1:0] h, m, s;
  logic [BLINK_W-1:0] blink_cnt;
  logic               phase;

  // Out-of-range captures behave like the maximum on +1 and like 0 on -1.
  function automatic logic [FIELD_W-1:0] inc_wrap(input logic [FIELD_W-1:0] v,
                                                  input logic [FIELD_W-1:0] max);
    return (v >= max) ? '0 : v + 1'b1;
  endfunction

  function automatic logic [FIELD_W-1:0] dec_wrap(input logic [FIELD_W-1:0] v,
                                                  input logic [FIELD_W-1:0] max);
    return (v == '0 || v > max) ? max : v - 1'b1;
  endfunction

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clk(CLK100MHZ), .reset(reset), .btn(BTNC), .press(mode_p));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk(CLK100MHZ), .reset(reset), .btn(BTNU), .press(up_p));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
    .clk(CLK100MHZ), .reset(reset), .btn(BTND), .press(down_p));

  // mode pre-empts stepping; opposing steps cancel
  assign step_up = up_p & ~down_p & ~mode_p;
  assign step_dn = down_p & ~up_p & ~mode_p;

  always_ff @(posedge CLK100MHZ) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      RUN:    if (mode_p) state_nxt = EDIT_H;
      EDIT_H: if (mode_p) state_nxt = EDIT_M;
      EDIT_M: if (mode_p) state_nxt = EDIT_S;
      EDIT_S: if (mode_p) begin
        state_nxt = RUN;
        load      = ~reset;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      h <= '0;
      m <= '0;
      s <= '0;
    end else if (state == RUN && mode_p) begin
      h <= horas_in;
      m <= minutos_in;
      s <= segundos_in;
    end else begin
      case (state)
        EDIT_H: if (step_up) h <= inc_wrap(h, HOURS_MAX);
                else if (step_dn) h <= dec_wrap(h, HOURS_MAX);
        EDIT_M: if (step_up) m <= inc_wrap(m, MINSEC_MAX);
                else if (step_dn) m <= dec_wrap(m, MINSEC_MAX);
        EDIT_S: if (step_up) s <= inc_wrap(s, MINSEC_MAX);
                else if (step_dn) s <= dec_wrap(s, MINSEC_MAX);
        default: ;
      endcase
    end
  end

  // Restarting on each field change makes a newly selected field visible first.
  always_ff @(posedge CLK100MHZ) begin
    if (reset || state_nxt != state) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_comb begin
    active = FLD_H;
    case (state)
      EDIT_M:  active = FLD_M;
      EDIT_S:  active = FLD_S;
      default: active = FLD_H;
    endcase
  end

  assign editing      = (state != RUN);
  assign blink_mask   = editing ? (3'(phase) << active) : 3'b000;
  assign horas_set    = h;
  assign minutos_set  = m;
  assign segundos_set = s;

endmodule
